// File: rtl/time_text_pixel.sv
// Race-time text overlay: aligns sync/video/game pixel with the font ROM read and mixes glyph pixels over the game picture.
// Optional blink of the text while paused is built when TIME_TEXT_BLINK_EN is defined.
module time_text_pixel #(
   parameter int unsigned ROM_LAT      = 1,
   parameter logic [11:0] TEXT_RGB     = 12'hFFF,
   parameter logic [11:0] TEXT_BG_RGB  = 12'h000,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pause,
   input  logic        refresh_tick,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        time_on,
   input  logic [2:0]  bit_addr,
   input  logic [7:0]  font_word,
   input  logic [11:0] game_rgb,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync
);

   localparam int unsigned CNT_W = 8;

   typedef struct packed {
      logic        time_on;
      logic [2:0]  bit_addr;
      logic        video_on;
      logic        hsync;
      logic        vsync;
      logic [11:0] game_rgb;
   } stage_t;

   localparam stage_t STAGE_RST = '{
      time_on:  1'b0,
      bit_addr: 3'd0,
      video_on: 1'b0,
      hsync:    1'b1,
      vsync:    1'b1,
      game_rgb: 12'h000
   };

   stage_t      pipe [ROM_LAT];
   stage_t      tail_c;
   logic        font_bit_c;
   logic        blink_phase;
   logic [11:0] rgb_nxt_c;

   // Free-running delay line matching the font ROM read latency
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < int'(ROM_LAT); k++) pipe[k] <= STAGE_RST;
      end else begin
         pipe[0] <= '{
            time_on:  time_on,
            bit_addr: bit_addr,
            video_on: video_on,
            hsync:    hsync_in,
            vsync:    vsync_in,
            game_rgb: game_rgb
         };
         for (int k = 1; k < int'(ROM_LAT); k++) pipe[k] <= pipe[k-1];
      end
   end

   assign tail_c = pipe[ROM_LAT-1];

   // Column 0 is the MSB of the row word; ~x equals 7-x on 3 bits
   assign font_bit_c = font_word[~tail_c.bit_addr];

`ifdef TIME_TEXT_BLINK_EN
   typedef enum logic {
      HIDE = 1'b0,
      SHOW = 1'b1
   } blink_state_t;

   blink_state_t       blink_state;
   logic [CNT_W-1:0]   blink_cnt;

   // Blink half-period counter; unpausing snaps back to visible text
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_state <= SHOW;
         blink_cnt   <= '0;
      end else if (!pause) begin
         blink_state <= SHOW;
         blink_cnt   <= '0;
      end else if (refresh_tick) begin
         if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            case (blink_state)
               SHOW:    blink_state <= HIDE;
               default: blink_state <= SHOW;
            endcase
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign blink_phase = (blink_state == SHOW);
`else
   logic unused_blink_in;
   assign unused_blink_in = &{1'b0, pause, refresh_tick, CNT_W'(BLINK_FRAMES)};
   assign blink_phase     = 1'b1;
`endif

   // Colour priority: blanking, lit glyph, text background, game picture
   always_comb begin
      rgb_nxt_c = tail_c.game_rgb;
      if (!tail_c.video_on)
         rgb_nxt_c = 12'h000;
      else if (tail_c.time_on && font_bit_c && blink_phase)
         rgb_nxt_c = TEXT_RGB;
      else if (tail_c.time_on)
         rgb_nxt_c = TEXT_BG_RGB;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb   <= 12'h000;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         rgb   <= rgb_nxt_c;
         hsync <= tail_c.hsync;
         vsync <= tail_c.vsync;
      end
   end

endmodule

// File: tb/tb_time_text_pixel.sv
// Directed bench for time_text_pixel: colour table, latency at ROM_LAT 1 and 2, sync delay, async reset, blink.
module tb_time_text_pixel;

   localparam logic [11:0] TXT = 12'hFFF;
   localparam logic [11:0] BG  = 12'h00F;

   logic        clk = 1'b0;
   logic        reset;
   logic        pause, refresh_tick, video_on, hsync_in, vsync_in, time_on;
   logic [2:0]  bit_addr;
   logic [7:0]  font_word1, font_word2;
   logic [11:0] game_rgb;
   logic [11:0] rgb1, rgb2;
   logic        hsync1, vsync1, hsync2, vsync2;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   time_text_pixel #(.ROM_LAT(1), .TEXT_RGB(TXT), .TEXT_BG_RGB(BG), .BLINK_FRAMES(2)) dut1 (
      .clk(clk), .reset(reset), .pause(pause), .refresh_tick(refresh_tick),
      .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .time_on(time_on), .bit_addr(bit_addr), .font_word(font_word1),
      .game_rgb(game_rgb), .rgb(rgb1), .hsync(hsync1), .vsync(vsync1)
   );

   time_text_pixel #(.ROM_LAT(2), .TEXT_RGB(TXT), .TEXT_BG_RGB(BG), .BLINK_FRAMES(2)) dut2 (
      .clk(clk), .reset(reset), .pause(pause), .refresh_tick(refresh_tick),
      .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .time_on(time_on), .bit_addr(bit_addr), .font_word(font_word2),
      .game_rgb(game_rgb), .rgb(rgb2), .hsync(hsync2), .vsync(vsync2)
   );

   typedef struct {
      logic        vid;
      logic        ton;
      logic [2:0]  ba;
      logic [7:0]  fw;
      logic [11:0] grgb;
      logic        hs;
      logic        vs;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t vecs [16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic hs_pat(input int i);
      return (i >= 4 && i < 100) ? 1'b0 : 1'b1;
   endfunction

   task automatic tick();
      refresh_tick = 1'b1;
      step();
      refresh_tick = 1'b0;
      step();
      step();
   endtask

   task automatic set_lit();
      video_on = 1'b1; time_on = 1'b1; bit_addr = 3'd0;
      font_word1 = 8'h80; font_word2 = 8'h80; game_rgb = 12'h0F0;
   endtask

   initial begin
      int lows1, lows2;
      logic [11:0] blink_exp [4];

      // Colour table: steady inputs, expected rgb computed by hand
      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b1, 1'b1, 3'(i), 8'h01, 12'h0F0, 1'b1, 1'b1, (i == 7) ? TXT : BG};
      vecs[8]  = '{1'b1, 1'b1, 3'd0, 8'h80, 12'h0F0, 1'b0, 1'b1, TXT};
      vecs[9]  = '{1'b1, 1'b1, 3'd2, 8'hA5, 12'h0F0, 1'b1, 1'b0, TXT};
      vecs[10] = '{1'b1, 1'b1, 3'd1, 8'hA5, 12'h0F0, 1'b0, 1'b0, BG};
      vecs[11] = '{1'b1, 1'b0, 3'd0, 8'h00, 12'h0F0, 1'b1, 1'b1, 12'h0F0};
      vecs[12] = '{1'b0, 1'b0, 3'd0, 8'h00, 12'h0F0, 1'b1, 1'b1, 12'h000};
      vecs[13] = '{1'b0, 1'b1, 3'd0, 8'h80, 12'h0F0, 1'b1, 1'b1, 12'h000};
      vecs[14] = '{1'b1, 1'b0, 3'd0, 8'hFF, 12'h123, 1'b1, 1'b1, 12'h123};
      vecs[15] = '{1'b1, 1'b1, 3'd7, 8'hFE, 12'h0F0, 1'b1, 1'b1, BG};

      reset = 1'b0; pause = 1'b0; refresh_tick = 1'b0;
      video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; time_on = 1'b0;
      bit_addr = 3'd0; font_word1 = 8'h00; font_word2 = 8'h00; game_rgb = 12'h000;
      step(); step();
      chk("reset_rgb1", rgb1, 12'h000);
      chk("reset_hs1", 12'(hsync1), 12'h001);
      chk("reset_vs1", 12'(vsync1), 12'h001);
      chk("reset_rgb2", rgb2, 12'h000);
      reset = 1'b1;
      step(); step(); step();

      for (int i = 0; i < 16; i++) begin
         video_on = vecs[i].vid; time_on = vecs[i].ton; bit_addr = vecs[i].ba;
         font_word1 = vecs[i].fw; font_word2 = vecs[i].fw; game_rgb = vecs[i].grgb;
         hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
         step(); step(); step();
         chk($sformatf("vec%0d_rgb1", i), rgb1, vecs[i].exp_rgb);
         chk($sformatf("vec%0d_rgb2", i), rgb2, vecs[i].exp_rgb);
         chk($sformatf("vec%0d_hs1", i), 12'(hsync1), 12'(vecs[i].hs));
         chk($sformatf("vec%0d_vs1", i), 12'(vsync1), 12'(vecs[i].vs));
      end

      // Single-pixel latency: ROM_LAT+1 cycles for both instances
      video_on = 1'b0; time_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      font_word1 = 8'h00; font_word2 = 8'h00; game_rgb = 12'h0F0;
      step(); step(); step();
      for (int i = 0; i < 8; i++) begin
         video_on = (i == 2); time_on = (i == 2); bit_addr = 3'd0;
         font_word1 = (i == 3) ? 8'h80 : 8'h00;
         font_word2 = (i == 4) ? 8'h80 : 8'h00;
         step();
         chk($sformatf("lat1_c%0d", i), rgb1, (i == 3) ? TXT : 12'h000);
         chk($sformatf("lat2_c%0d", i), rgb2, (i == 4) ? TXT : 12'h000);
      end

      // 96-cycle hsync pulse, shifted by 2 and 3 cycles
      lows1 = 0; lows2 = 0;
      for (int i = 0; i < 110; i++) begin
         hsync_in = hs_pat(i);
         step();
         chk($sformatf("hs1_c%0d", i), 12'(hsync1), 12'(hs_pat(i - 1)));
         chk($sformatf("hs2_c%0d", i), 12'(hsync2), 12'(hs_pat(i - 2)));
         if (!hsync1) lows1++;
         if (!hsync2) lows2++;
      end
      chk("hs1_low_len", 12'(lows1), 12'd96);
      chk("hs2_low_len", 12'(lows2), 12'd96);

      // Asynchronous reset in the middle of a line
      set_lit(); hsync_in = 1'b0; vsync_in = 1'b0;
      step(); step(); step();
      chk("pre_rst_rgb1", rgb1, TXT);
      chk("pre_rst_hs1", 12'(hsync1), 12'h000);
      #2 reset = 1'b0;
      #1;
      chk("arst_rgb1", rgb1, 12'h000);
      chk("arst_hs1", 12'(hsync1), 12'h001);
      chk("arst_vs1", 12'(vsync1), 12'h001);
      chk("arst_rgb2", rgb2, 12'h000);
      chk("arst_hs2", 12'(hsync2), 12'h001);
      step(); step();
      reset = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("rel_rgb1_c%0d", i), rgb1, (i >= 2) ? TXT : 12'h000);
         chk($sformatf("rel_hs1_c%0d", i), 12'(hsync1), (i >= 2) ? 12'h000 : 12'h001);
         chk($sformatf("rel_rgb2_c%0d", i), rgb2, (i >= 3) ? TXT : 12'h000);
      end
      hsync_in = 1'b1; vsync_in = 1'b1;

`ifdef TIME_TEXT_BLINK_EN
      // BLINK_FRAMES=2: shown frames 0-1, hidden 2-3, shown at 4
      blink_exp = '{TXT, BG, BG, TXT};
      pause = 1'b1;
      step();
      chk("blink_f0", rgb1, TXT);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("blink_f%0d", k + 1), rgb1, blink_exp[k]);
      end
      tick();
      chk("blink_f5", rgb1, TXT);
      tick();
      chk("blink_f6", rgb1, BG);
      pause = 1'b0;
      step(); step();
      chk("unpause_in_hide", rgb1, TXT);

      // Clear wins over a coincident refresh_tick
      pause = 1'b1;
      step();
      tick();
      chk("coinc_pre", rgb1, TXT);
      pause = 1'b0; refresh_tick = 1'b1;
      step();
      refresh_tick = 1'b0; pause = 1'b1;
      step();
      chk("coinc_phase", rgb1, TXT);
      tick();
      chk("coinc_cnt1", rgb1, TXT);
      tick();
      chk("coinc_cnt_wrap", rgb1, BG);
`else
      blink_exp = '{TXT, TXT, TXT, TXT};
      pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("noblink_f%0d", k + 1), rgb1, blink_exp[k % 4]);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
